multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: five-state IF/ID/EX/MEM/WB sequencer with
// RV32-subset decode, a bounded data-memory wait with a sticky timeout
// flag, and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        loadPC,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        illegal,
  output logic        err,
  output logic [15:0] retired
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [31:0]   ir;
  logic [CW-1:0] wcnt;
  logic [2:0]    nxt;

  logic [31:0] src;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_r, is_i, is_lw, is_sw, is_beq;
  logic        alu_ok, legal, alu_src_dec;
  logic [3:0]  alu_dec;
  logic        set_err, retire, timeout;

  // Decode: the live instruction word during ID, the captured ir afterwards
  always_comb begin
    src     = (state == S_ID) ? instr : ir;
    opcode  = src[6:0];
    funct3  = src[14:12];
    is_r    = (opcode == 7'b0110011);
    is_i    = (opcode == 7'b0010011);
    is_lw   = (opcode == 7'b0000011);
    is_sw   = (opcode == 7'b0100011);
    is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
    alu_ok  = 1'b1;
    alu_dec = 4'b0000;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_dec = (is_r && src[30]) ? 4'b0110 : 4'b0010;
        3'b111:  alu_dec = 4'b0000;
        3'b110:  alu_dec = 4'b0001;
        3'b100:  alu_dec = 4'b0101;
        3'b010:  alu_dec = 4'b0111;
        default: alu_ok  = 1'b0;
      endcase
    end else if (is_lw || is_sw) begin
      alu_dec = 4'b0010;
    end else if (is_beq) begin
      alu_dec = 4'b0110;
    end
    legal       = ((is_r || is_i) && alu_ok) || is_lw || is_sw || is_beq;
    alu_src_dec = is_i || is_lw || is_sw;
  end

  // Next state, datapath strobes and bookkeeping events
  always_comb begin
    nxt      = S_IF;
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUCtrl  = 4'b0000;
    illegal  = 1'b0;
    set_err  = 1'b0;
    retire   = 1'b0;
    timeout  = (wcnt == CW'(MEM_TIMEOUT));
    case (state)
      S_IF: nxt = S_ID;
      S_ID: begin
        if (legal) begin
          nxt = S_EX;
        end else begin
          illegal = 1'b1;
          loadPC  = 1'b1;
        end
      end
      S_EX: begin
        ALUCtrl = alu_dec;
        ALUSrc  = alu_src_dec;
        if (is_beq) begin
          loadPC = 1'b1;
          PCSrc  = zero;
          retire = 1'b1;
        end else if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        ALUCtrl  = alu_dec;
        ALUSrc   = alu_src_dec;
        MemRead  = is_lw;
        MemWrite = is_sw;
        // mem_ready beats the timeout when both land in the same cycle
        if (mem_ready) begin
          if (is_lw) begin
            nxt = S_WB;
          end else begin
            loadPC = 1'b1;
            retire = 1'b1;
          end
        end else if (timeout) begin
          set_err = 1'b1;
          loadPC  = 1'b1;
          retire  = 1'b1;
        end else begin
          nxt = S_MEM;
        end
      end
      S_WB: begin
        ALUCtrl  = alu_dec;
        ALUSrc   = alu_src_dec;
        RegWrite = 1'b1;
        loadPC   = 1'b1;
        MemToReg = is_lw;
        retire   = 1'b1;
      end
      default: nxt = S_IF;
    endcase
  end

  // State register, instruction capture, MEM wait counter, err and retired
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IF;
      ir      <= '0;
      wcnt    <= '0;
      err     <= 1'b0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (state == S_ID && legal) ir <= instr;
      // Held at zero outside MEM, so every MEM entry starts counting from 0
      if (state != S_MEM)  wcnt <= '0;
      else if (!mem_ready) wcnt <= wcnt + 1'b1;
      if (set_err) err <= 1'b1;
      if (retire)  retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  state;
  logic        loadPC, PCSrc, ALUSrc, MemRead, MemWrite, RegWrite, MemToReg;
  logic [3:0]  ALUCtrl;
  logic        illegal, err;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle trace of one instruction, index 0 = IF cycle
  int         ncyc;
  logic [2:0] st_t [40];
  logic       lp_t [40];
  logic       pcs_t[40];
  logic       as_t [40];
  logic       mr_t [40];
  logic       mw_t [40];
  logic       rw_t [40];
  logic       m2r_t[40];
  logic       ill_t[40];
  logic [3:0] alu_t[40];

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SLL  = 32'h002091B3;
  localparam logic [31:0] I_XORI = 32'h0050C093;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .state(state), .loadPC(loadPC), .PCSrc(PCSrc), .ALUSrc(ALUSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .ALUCtrl(ALUCtrl), .illegal(illegal), .err(err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one instruction from IF until the FSM is back in IF (bounded).
  // mem_ready rises on MEM cycle rdy_at (-1 = never); noise drives mem_ready outside MEM.
  task automatic run(input logic [31:0] ins, input logic z, input int rdy_at, input logic noise);
    int memidx = 0;
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      instr     = ins;
      zero      = z;
      mem_ready = (state == 3'd3) ? (memidx == rdy_at) : noise;
      #1;
      st_t[i] = state;   lp_t[i] = loadPC;   pcs_t[i] = PCSrc;  as_t[i] = ALUSrc;
      mr_t[i] = MemRead; mw_t[i] = MemWrite; rw_t[i] = RegWrite;
      m2r_t[i] = MemToReg; ill_t[i] = illegal; alu_t[i] = ALUCtrl;
      if (state == 3'd3) memidx++;
      @(posedge clk); #1;
      ncyc = i + 1;
      if (state == 3'd0) break;
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   state,   3'd0);
    chk("rst_err",     err,     1'b0);
    chk("rst_retired", retired, 16'd0);
    chk("rst_loadpc",  loadPC,  1'b0);
    chk("rst_alu",     ALUCtrl, 4'd0);
    rst = 1'b1;

    // add x3,x1,x2
    run(I_ADD, 1'b0, -1, 1'b1);
    chk("add_cycles", ncyc, 4);
    chk("add_st0", st_t[0], 3'd0); chk("add_st1", st_t[1], 3'd1);
    chk("add_st2", st_t[2], 3'd2); chk("add_st3", st_t[3], 3'd4);
    chk("add_if_alu", alu_t[0], 4'd0); chk("add_id_alu", alu_t[1], 4'd0);
    chk("add_ex_alu", alu_t[2], 4'b0010);
    chk("add_ex_alusrc", as_t[2], 1'b0);
    chk("add_ex_rw", rw_t[2], 1'b0); chk("add_ex_lp", lp_t[2], 1'b0);
    chk("add_wb_rw", rw_t[3], 1'b1); chk("add_wb_lp", lp_t[3], 1'b1);
    chk("add_wb_m2r", m2r_t[3], 1'b0);
    chk("add_retired", retired, 16'd1);

    // lw: mem_ready low for 3 MEM cycles, high on the 4th
    run(I_LW, 1'b0, 3, 1'b1);
    chk("lw_cycles", ncyc, 8);
    cnt = 0;
    for (int i = 0; i < 8; i++) if (mr_t[i]) cnt++;
    chk("lw_memread_cycles", cnt, 4);
    chk("lw_st6", st_t[6], 3'd3); chk("lw_st7", st_t[7], 3'd4);
    chk("lw_ex_alu", alu_t[2], 4'b0010); chk("lw_ex_alusrc", as_t[2], 1'b1);
    chk("lw_mem_lp", lp_t[6], 1'b0);
    chk("lw_wb_m2r", m2r_t[7], 1'b1); chk("lw_wb_rw", rw_t[7], 1'b1);
    chk("lw_wb_memread", mr_t[7], 1'b0);
    chk("lw_retired", retired, 16'd2);

    // beq taken / not taken
    run(I_BEQ, 1'b1, -1, 1'b0);
    chk("beq1_cycles", ncyc, 3);
    chk("beq1_lp", lp_t[2], 1'b1); chk("beq1_pcsrc", pcs_t[2], 1'b1);
    chk("beq1_alu", alu_t[2], 4'b0110);
    chk("beq1_retired", retired, 16'd3);
    run(I_BEQ, 1'b0, -1, 1'b0);
    chk("beq0_cycles", ncyc, 3);
    chk("beq0_lp", lp_t[2], 1'b1); chk("beq0_pcsrc", pcs_t[2], 1'b0);
    chk("beq0_retired", retired, 16'd4);

    // xori (I-ALU) and sub (R, funct7[5]=1)
    run(I_XORI, 1'b0, -1, 1'b0);
    chk("xori_cycles", ncyc, 4);
    chk("xori_alu", alu_t[2], 4'b0101); chk("xori_alusrc", as_t[2], 1'b1);
    run(I_SUB, 1'b0, -1, 1'b0);
    chk("sub_alu", alu_t[2], 4'b0110);
    chk("sub_retired", retired, 16'd6);

    // R-type with unsupported funct3 is illegal
    run(I_SLL, 1'b0, -1, 1'b0);
    chk("sll_cycles", ncyc, 2);
    chk("sll_illegal", ill_t[1], 1'b1);
    chk("sll_retired", retired, 16'd6);

    // sw with mem_ready arriving in the timeout cycle: normal completion
    run(I_SW, 1'b0, 15, 1'b0);
    chk("swlate_cycles", ncyc, 19);
    chk("swlate_lp", lp_t[18], 1'b1);
    chk("swlate_err", err, 1'b0);
    chk("swlate_retired", retired, 16'd7);

    // opcode 0x7F
    run(I_BAD, 1'b0, -1, 1'b0);
    chk("bad_cycles", ncyc, 2);
    chk("bad_if_illegal", ill_t[0], 1'b0);
    chk("bad_id_illegal", ill_t[1], 1'b1);
    chk("bad_lp", lp_t[1], 1'b1); chk("bad_pcsrc", pcs_t[1], 1'b0);
    chk("bad_next_state", state, 3'd0);
    chk("bad_retired", retired, 16'd7);

    // sw that never completes: timeout abort
    run(I_SW, 1'b0, -1, 1'b0);
    chk("swto_cycles", ncyc, 19);
    cnt = 0;
    for (int i = 0; i < 19; i++) if (mw_t[i]) cnt++;
    chk("swto_memwrite_cycles", cnt, 16);
    chk("swto_lp", lp_t[18], 1'b1); chk("swto_pcsrc", pcs_t[18], 1'b0);
    chk("swto_prev_lp", lp_t[17], 1'b0);
    chk("swto_err", err, 1'b1);
    chk("swto_state", state, 3'd0);
    chk("swto_retired", retired, 16'd8);

    // reset during sw MEM wait
    instr = I_SW; zero = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 10 && state != 3'd3; i++) begin
      @(posedge clk); #1;
    end
    chk("rstmem_entered", state, 3'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("rstmem_memwrite_before", MemWrite, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmem_memwrite", MemWrite, 1'b0);
    chk("rstmem_state", state, 3'd0);
    chk("rstmem_err", err, 1'b0);
    chk("rstmem_retired", retired, 16'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmem_release", state, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
